feature_map_mem: RTL and testbench
==================================

// Module: feature_map_mem
// PURPOSE
//  Responder side of the convolution unit's memory read/write port pair.
//  Stores one CHANNELS x BITS_PER_CHANNEL feature-map word per pixel.
//  Serves single-cycle-issue reads (1-cycle latency) and same-cycle writes.
//  Write-first forwarding lets the convolution's pipelined RMW stream run back-to-back.
//  Also provides a bulk clear sweep used between frames.
// PARAMETERS
//  COORD_BITS        DEFAULT_COORD_BITS    width of each x/y coordinate field
//  CHANNELS          DEFAULT_CHANNELS      channels per pixel word
//  BITS_PER_CHANNEL  DEFAULT_NEURON_BITS   bits per channel state
//  IMG_WIDTH         DEFAULT_IMG_WIDTH     valid x range 0..IMG_WIDTH-1
//  IMG_HEIGHT        DEFAULT_IMG_HEIGHT    valid y range 0..IMG_HEIGHT-1
//  (derived) DEPTH = IMG_WIDTH*IMG_HEIGHT; W = CHANNELS*BITS_PER_CHANNEL
// PORTS
//  clk          in   1           clock
//  reset        in   1           async, active-high reset
//  read_req     in   1           read request, sampled at posedge
//  coord_get_x  in   COORD_BITS  read x
//  coord_get_y  in   COORD_BITS  read y
//  data_out     out  W           read data; channel i at [i*BITS_PER_CHANNEL +: BITS_PER_CHANNEL]
//  read_valid   out  1           data_out holds the response to the previous cycle's read_req
//  write_req    in   1           write request, sampled at posedge
//  coord_wtr_x  in   COORD_BITS  write x
//  coord_wtr_y  in   COORD_BITS  write y
//  data_in      in   W           write data, same packing as data_out
//  clear_req    in   1           start a zeroing sweep of all DEPTH words
//  busy         out  1           clear sweep in progress
//  clear_done   out  1           1-cycle pulse after the last word is zeroed
//  access_err   out  1           1-cycle pulse: out-of-range or blocked access
// BEHAVIOUR
//  Reset values: data_out=0, read_valid=0, busy=0, clear_done=0, access_err=0, FSM=IDLE.
//    RAM contents are not reset.
//  Address map: addr = y*IMG_WIDTH + x, unsigned; in range iff x<IMG_WIDTH and y<IMG_HEIGHT.
//  Read: read_req at edge N -> data_out/read_valid at N+1. read_valid=0 when no read was taken.
//    data_out holds its last value when read_valid=0.
//  Write: write_req at edge N commits data_in to addr at edge N.
//    A read at N+1 of that addr returns the new data.
//  Same-cycle read+write to the same in-range addr: the read returns data_in (write-first).
//  Different addrs in the same cycle: both complete independently, with no stall.
//  Out-of-range read: data_out=0 with read_valid=1, access_err=1 at N+1.
//  Out-of-range write: dropped, access_err=1 at N+1. RAM is unchanged.
//  FSM IDLE: clear_req=1 -> CLEARING, clr_cnt=0, busy=1 from the next cycle.
//  FSM CLEARING: writes 0 to addr clr_cnt each cycle, clr_cnt++.
//    At clr_cnt==DEPTH-1: that word is zeroed, FSM -> IDLE, busy=0 and clear_done=1 next cycle.
//    The sweep takes exactly DEPTH cycles.
//  During CLEARING:
//    reads return 0 with read_valid=1 and access_err=1;
//    writes are dropped with access_err=1;
//    clear_req is ignored.
//  clear_req together with read/write in IDLE: the access is served normally this cycle,
//    and the sweep starts the next cycle.
//  Reset mid-sweep: FSM -> IDLE, clr_cnt=0, no clear_done. RAM is left partially cleared.
//  Widths: clr_cnt is $clog2(DEPTH) bits. Address arithmetic is done at $clog2(DEPTH)+1 bits,
//    so no wrap occurs.
// TESTING (IMG 8x8, CHANNELS=4, BITS=8)
//  1. After clear, write (3,2)=0x04030201, then read (3,2) next cycle
//     -> data_out=0x04030201, read_valid=1 one cycle after read_req.
//  2. Same cycle: write (5,5)=0xAABBCCDD and read (5,5) -> data_out=0xAABBCCDD (forwarding).
//     Same cycle: write (1,0) and read (2,0) -> (2,0) returns its old value.
//  3. Back-to-back stream: read k+1 while writing k for 9 coords -> every write lands,
//     every read_valid is contiguous, with no bubble.
//  4. Read (8,0) -> data_out=0, access_err pulse. Write (0,8) -> dropped;
//     a later read of (0,0) is unchanged.
//  5. clear_req -> busy high for exactly 64 cycles, clear_done 1 pulse;
//     all 64 reads then return 0. A write issued mid-sweep is dropped with access_err.
//  6. Assert reset at sweep cycle 20 -> busy=0 and read_valid=0 immediately, no clear_done.
//     Words 0..19 are 0, word 40 keeps its old value.

Source files
------------

// File: rtl/feature_map_mem.sv
// Feature-map pixel store: 1-cycle registered reads, same-edge writes with
// write-first forwarding, and a DEPTH-cycle zeroing sweep between frames.
module feature_map_mem #(
  parameter int COORD_BITS       = 4,
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 8,
  parameter int IMG_WIDTH        = 8,
  parameter int IMG_HEIGHT       = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 read_req,
  input  logic [COORD_BITS-1:0]                coord_get_x,
  input  logic [COORD_BITS-1:0]                coord_get_y,
  output logic [CHANNELS*BITS_PER_CHANNEL-1:0] data_out,
  output logic                                 read_valid,
  input  logic                                 write_req,
  input  logic [COORD_BITS-1:0]                coord_wtr_x,
  input  logic [COORD_BITS-1:0]                coord_wtr_y,
  input  logic [CHANNELS*BITS_PER_CHANNEL-1:0] data_in,
  input  logic                                 clear_req,
  output logic                                 busy,
  output logic                                 clear_done,
  output logic                                 access_err
);

  localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
  localparam int W     = CHANNELS * BITS_PER_CHANNEL;
  localparam int AW    = $clog2(DEPTH);
  localparam int AAW   = AW + 1;

  localparam logic [COORD_BITS:0] X_LIM    = (COORD_BITS+1)'(IMG_WIDTH);
  localparam logic [COORD_BITS:0] Y_LIM    = (COORD_BITS+1)'(IMG_HEIGHT);
  localparam logic [AAW-1:0]      WIDTH_A  = AAW'(IMG_WIDTH);
  localparam logic [AW-1:0]       LAST_CNT = AW'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEARING = 1'b1} state_t;

  state_t         state_q;
  logic [AW-1:0]  clr_cnt_q;
  logic           busy_q;
  logic           clear_done_q;
  logic [W-1:0]   data_out_q, data_out_d;
  logic           read_valid_q, read_valid_d;
  logic           access_err_q, access_err_d;

  logic [W-1:0]   mem_q [DEPTH];

  logic           rd_in_s, wr_in_s, rd_ok_s, wr_ok_s;
  logic [AAW-1:0] rd_addr_s, wr_addr_s;
  logic           mem_we_s;
  logic [AW-1:0]  mem_waddr_s;
  logic [W-1:0]   mem_wdata_s;

  assign rd_in_s   = ({1'b0, coord_get_x} < X_LIM) && ({1'b0, coord_get_y} < Y_LIM);
  assign wr_in_s   = ({1'b0, coord_wtr_x} < X_LIM) && ({1'b0, coord_wtr_y} < Y_LIM);
  assign rd_addr_s = AAW'(coord_get_y) * WIDTH_A + AAW'(coord_get_x);
  assign wr_addr_s = AAW'(coord_wtr_y) * WIDTH_A + AAW'(coord_wtr_x);
  assign rd_ok_s   = read_req  && (state_q == IDLE) && rd_in_s;
  assign wr_ok_s   = write_req && (state_q == IDLE) && wr_in_s;

  // Read response, error flag and the single RAM write port (sweep owns it while clearing)
  always_comb begin
    data_out_d   = data_out_q;
    read_valid_d = read_req;
    if (read_req) begin
      if (rd_ok_s) begin
        data_out_d = (wr_ok_s && (wr_addr_s == rd_addr_s)) ? data_in
                                                           : mem_q[rd_addr_s[AW-1:0]];
      end else begin
        data_out_d = '0;
      end
    end else begin
      data_out_d = data_out_q;
    end
    access_err_d = (read_req && !rd_ok_s) || (write_req && !wr_ok_s);

    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (state_q == CLEARING) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_cnt_q;
      mem_wdata_s = '0;
    end else if (wr_ok_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = wr_addr_s[AW-1:0];
      mem_wdata_s = data_in;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Clear-sweep FSM with registered busy/clear_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q   <= CLEARING;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        CLEARING: begin
          if (clr_cnt_q == LAST_CNT) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          clr_cnt_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Registered read-port outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      read_valid_q <= read_valid_d;
      access_err_q <= access_err_d;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign data_out   = data_out_q;
  assign read_valid = read_valid_q;
  assign busy       = busy_q;
  assign clear_done = clear_done_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_feature_map_mem.sv
// Scoreboard bench for feature_map_mem (8x8 image, 4 channels x 8 bits).
module tb_feature_map_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_req, write_req, clear_req;
  logic [3:0]  coord_get_x, coord_get_y, coord_wtr_x, coord_wtr_y;
  logic [31:0] data_in, data_out;
  logic        read_valid, busy, clear_done, access_err;

  typedef struct {
    logic        rv;
    logic [31:0] d;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  feature_map_mem dut (
    .clk(clk), .reset(reset),
    .read_req(read_req), .coord_get_x(coord_get_x), .coord_get_y(coord_get_y),
    .data_out(data_out), .read_valid(read_valid),
    .write_req(write_req), .coord_wtr_x(coord_wtr_x), .coord_wtr_y(coord_wtr_y),
    .data_in(data_in), .clear_req(clear_req),
    .busy(busy), .clear_done(clear_done), .access_err(access_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".read_valid"}, {31'd0, read_valid}, {31'd0, e.rv});
        chk({e.name, ".access_err"}, {31'd0, access_err}, {31'd0, e.err});
        if (e.rv) chk({e.name, ".data_out"}, data_out, e.d);
      end
    end
  endtask

  task automatic status_count();
    forever begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_cnt++;
      if (clear_done === 1'b1) done_cnt++;
    end
  endtask

  task automatic step(input string name,
                      input logic rr, input int rx, input int ry,
                      input logic wr, input int wx, input int wy, input logic [31:0] wd,
                      input logic clr,
                      input logic erv, input logic [31:0] ed, input logic eerr);
    exp_t e;
    @(negedge clk);
    read_req    = rr;
    coord_get_x = 4'(rx);
    coord_get_y = 4'(ry);
    write_req   = wr;
    coord_wtr_x = 4'(wx);
    coord_wtr_y = 4'(wy);
    data_in     = wd;
    clear_req   = clr;
    e.rv = erv; e.d = ed; e.err = eerr; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string name);
    step(name, 1'b0, 0, 0, 1'b0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rd(input string name, input int x, input int y, input logic [31:0] ed, input logic eerr);
    step(name, 1'b1, x, y, 1'b0, 0, 0, 32'd0, 1'b0, 1'b1, ed, eerr);
  endtask

  task automatic wrt(input string name, input int x, input int y, input logic [31:0] d, input logic eerr);
    step(name, 1'b0, 0, 0, 1'b1, x, y, d, 1'b0, 1'b0, 32'd0, eerr);
  endtask

  initial begin
    int b0, d0;
    fork
      monitor();
      status_count();
    join_none

    reset = 1'b1;
    read_req = 1'b0; write_req = 1'b0; clear_req = 1'b0;
    coord_get_x = 4'd0; coord_get_y = 4'd0; coord_wtr_x = 4'd0; coord_wtr_y = 4'd0;
    data_in = 32'd0;
    #7;
    chk("reset.data_out",   data_out, 32'd0);
    chk("reset.read_valid", {31'd0, read_valid}, 32'd0);
    chk("reset.busy",       {31'd0, busy}, 32'd0);
    chk("reset.clear_done", {31'd0, clear_done}, 32'd0);
    chk("reset.access_err", {31'd0, access_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // initial clear so RAM contents are known
    step("init_clr", 1'b0, 0, 0, 1'b0, 0, 0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 66; i++) idle("init_sweep");

    // 1: write then read next cycle
    wrt("t1_wr", 3, 2, 32'h04030201, 1'b0);
    rd("t1_rd", 3, 2, 32'h04030201, 1'b0);

    // 2: forwarding, and independent different-address access
    wrt("t2_pre", 2, 0, 32'h22220000, 1'b0);
    step("t2_fwd", 1'b1, 5, 5, 1'b1, 5, 5, 32'hAABBCCDD, 1'b0, 1'b1, 32'hAABBCCDD, 1'b0);
    step("t2_diff", 1'b1, 2, 0, 1'b1, 1, 0, 32'h11110000, 1'b0, 1'b1, 32'h22220000, 1'b0);
    rd("t2_rd10", 1, 0, 32'h11110000, 1'b0);
    rd("t2_rd55", 5, 5, 32'hAABBCCDD, 1'b0);

    // 3: back-to-back stream over words 48..56, read k while writing k-1
    for (int s = 0; s <= 9; s++) begin
      step("t3_stream", (s < 9) ? 1'b1 : 1'b0, (48 + s) % 8, (48 + s) / 8,
           (s > 0) ? 1'b1 : 1'b0, (47 + s) % 8, (47 + s) / 8, 32'h5000_0000 + 32'(s - 1),
           1'b0, (s < 9) ? 1'b1 : 1'b0, 32'd0, 1'b0);
    end
    for (int k = 0; k < 9; k++)
      rd("t3_back", (48 + k) % 8, (48 + k) / 8, 32'h5000_0000 + 32'(k), 1'b0);

    // 4: out-of-range accesses
    wrt("t4_pre", 0, 0, 32'h0000AA55, 1'b0);
    rd("t4_oor_rd", 8, 0, 32'd0, 1'b1);
    idle("t4_gap");
    wrt("t4_oor_wr", 0, 8, 32'hDEADBEEF, 1'b1);
    rd("t4_rd00", 0, 0, 32'h0000AA55, 1'b0);

    // 5: sweep with blocked accesses, then full readback
    b0 = busy_cnt; d0 = done_cnt;
    step("t5_clr", 1'b0, 0, 0, 1'b0, 0, 0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int c = 0; c < 70; c++) begin
      if (c == 10)      wrt("t5_blk_wr", 2, 0, 32'h12345678, 1'b1);
      else if (c == 11) rd("t5_blk_rd", 3, 2, 32'd0, 1'b1);
      else              idle("t5_sweep");
    end
    chk("t5_busy_cycles", 32'(busy_cnt - b0), 32'd64);
    chk("t5_clear_done",  32'(done_cnt - d0), 32'd1);
    for (int a = 0; a < 64; a++) rd("t5_zero", a % 8, a / 8, 32'd0, 1'b0);

    // 6: reset mid-sweep leaves RAM partially cleared
    wrt("t6_w5",  5, 0, 32'h00000055, 1'b0);
    wrt("t6_w19", 3, 2, 32'h00000019, 1'b0);
    wrt("t6_w20", 4, 2, 32'h00000020, 1'b0);
    wrt("t6_w40", 0, 5, 32'h00000040, 1'b0);
    rd("t6_pre_rd", 0, 5, 32'h00000040, 1'b0);
    d0 = done_cnt;
    step("t6_clr", 1'b1, 8, 8, 1'b0, 0, 0, 32'd0, 1'b1, 1'b1, 32'd0, 1'b1);
    for (int c = 0; c < 20; c++) rd("t6_sweep_rd", 1, 1, 32'd0, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    read_req = 1'b0; write_req = 1'b0; clear_req = 1'b0;
    #1;
    chk("t6_busy_at_reset", {31'd0, busy}, 32'd0);
    chk("t6_rv_at_reset",   {31'd0, read_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 70; c++) idle("t6_after");
    chk("t6_no_clear_done", 32'(done_cnt - d0), 32'd0);
    rd("t6_rd5",  5, 0, 32'd0, 1'b0);
    rd("t6_rd19", 3, 2, 32'd0, 1'b0);
    rd("t6_rd20", 4, 2, 32'h00000020, 1'b0);
    rd("t6_rd40", 0, 5, 32'h00000040, 1'b0);
    idle("end");

    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
